// File: rtl/can_rx.sv
// -----------------------------------------------------------------------------
// can_rx -- oversampling serial byte receiver (8N1, LSB first, idle high).
//
// The asynchronous line is brought into the i_Clock domain through a two-flop
// synchronizer. All decoding uses the second flop. A start bit is confirmed at
// its middle. Each data bit and the stop bit are then sampled one bit period
// apart. A good stop bit publishes the byte with a one-cycle o_Rx_DV pulse.
//
// Optional feature (macro CAN_RX_FRAME_ERR_EN):
//   When the macro is defined, a low stop bit raises a one-cycle
//   o_Rx_Frame_Err pulse. When it is undefined, o_Rx_Frame_Err is tied low.
//   In both builds a bad frame is discarded and the port list is the same.
//
// Parameters:
//   CLKS_PER_BIT   i_Clock cycles per serial bit (4..255, default 87)
//
// Ports:
//   i_Clock         in   sole clock, rising edge
//   i_Reset         in   synchronous, active-high reset
//   i_Rx_Serial     in   asynchronous serial line
//   o_Rx_DV         out  one-cycle pulse, valid frame received
//   o_Rx_Byte       out  last good byte, updated together with o_Rx_DV
//   o_Rx_Active     out  high from start detection to frame end/reject
//   o_Rx_Frame_Err  out  one-cycle pulse on a low stop bit (macro builds only)
// -----------------------------------------------------------------------------
module can_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);

  localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF_BIT = 8'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_t;

  // Both synchronizer flops reset high so that reset never looks like a start bit.
  logic       rx_meta_reg;
  logic       rx_s_reg;

  state_t     state_reg,   state_next;
  logic [7:0] counter_reg, counter_next;
  logic [2:0] index_reg,   index_next;
  logic [7:0] shift_reg,   shift_next;
  logic [7:0] byte_reg,    byte_next;
  logic       dv_reg,      dv_next;
  logic       active_reg,  active_next;
`ifdef CAN_RX_FRAME_ERR_EN
  logic       ferr_reg,    ferr_next;
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      state_reg   <= S_IDLE;
      counter_reg <= 8'd0;
      index_reg   <= 3'd0;
      shift_reg   <= 8'h00;
      byte_reg    <= 8'h00;
      dv_reg      <= 1'b0;
      active_reg  <= 1'b0;
`ifdef CAN_RX_FRAME_ERR_EN
      ferr_reg    <= 1'b0;
`endif
    end else begin
      rx_meta_reg <= i_Rx_Serial;
      rx_s_reg    <= rx_meta_reg;
      state_reg   <= state_next;
      counter_reg <= counter_next;
      index_reg   <= index_next;
      shift_reg   <= shift_next;
      byte_reg    <= byte_next;
      dv_reg      <= dv_next;
      active_reg  <= active_next;
`ifdef CAN_RX_FRAME_ERR_EN
      ferr_reg    <= ferr_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    index_next   = index_reg;
    shift_next   = shift_reg;
    byte_next    = byte_reg;
    active_next  = active_reg;
    // Both pulses default low, so they last one cycle (they clear in CLEANUP).
    dv_next      = 1'b0;
`ifdef CAN_RX_FRAME_ERR_EN
    ferr_next    = 1'b0;
`endif

    case (state_reg)
      S_IDLE: begin
        counter_next = 8'd0;
        index_next   = 3'd0;
        if (!rx_s_reg) begin
          state_next  = S_START;
          active_next = 1'b1;
        end
      end

      S_START: begin
        if (counter_reg == HALF_BIT) begin
          counter_next = 8'd0;
          if (!rx_s_reg) begin
            state_next = S_DATA;
          end else begin
            // The line went back high before mid-bit, so this was a glitch.
            state_next  = S_IDLE;
            active_next = 1'b0;
          end
        end else begin
          counter_next = counter_reg + 8'd1;
        end
      end

      S_DATA: begin
        if (counter_reg == BIT_LAST) begin
          counter_next          = 8'd0;
          shift_next[index_reg] = rx_s_reg;
          if (index_reg == 3'd7) begin
            index_next = 3'd0;
            state_next = S_STOP;
          end else begin
            index_next = index_reg + 3'd1;
          end
        end else begin
          counter_next = counter_reg + 8'd1;
        end
      end

      S_STOP: begin
        if (counter_reg == BIT_LAST) begin
          counter_next = 8'd0;
          state_next   = S_CLEANUP;
          active_next  = 1'b0;
          if (rx_s_reg) begin
            dv_next   = 1'b1;
            byte_next = shift_reg;
          end else begin
`ifdef CAN_RX_FRAME_ERR_EN
            ferr_next = 1'b1;
`endif
          end
        end else begin
          counter_next = counter_reg + 8'd1;
        end
      end

      S_CLEANUP: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next   = S_IDLE;
        counter_next = 8'd0;
        index_next   = 3'd0;
        active_next  = 1'b0;
      end
    endcase
  end

  assign o_Rx_DV     = dv_reg;
  assign o_Rx_Byte   = byte_reg;
  assign o_Rx_Active = active_reg;
`ifdef CAN_RX_FRAME_ERR_EN
  assign o_Rx_Frame_Err = ferr_reg;
`else
  assign o_Rx_Frame_Err = 1'b0;
`endif

endmodule

// File: doc/can_rx.md
CAN_RX -- requirements
Module: can_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, meaning i_Clock cycles per serial bit; legal range 4..255.
REQ-002 i_Clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_Reset  input  1  reset, synchronous, active-high.
REQ-004 i_Rx_Serial  input  1  asynchronous serial line; idle high, 8N1 frame, LSB first.
REQ-005 o_Rx_DV  output  1  one-cycle pulse when a frame with valid stop bit is received.
REQ-006 o_Rx_Byte  output  8  last received byte; stable until the next o_Rx_DV.
REQ-007 o_Rx_Active  output  1  high from start-bit detection until the frame ends or is rejected.
REQ-008 o_Rx_Frame_Err  output  1  one-cycle pulse when the stop bit samples low.

Function
REQ-009 i_Rx_Serial SHALL pass through a two-flop synchronizer; all decoding SHALL use the second flop (rx_s).
REQ-010 States SHALL be IDLE, START, DATA, STOP, CLEANUP; clock counter 8 bits; bit index 3 bits.
REQ-011 IDLE: counter=0, index=0; on rx_s==0 go to START and set o_Rx_Active=1.
REQ-012 START: count until counter==(CLKS_PER_BIT-1)/2 (integer division; 43 at default); then if rx_s==0 clear counter and go DATA, else go IDLE with o_Rx_Active=0 (glitch reject, no pulses).
REQ-013 DATA: count until counter==CLKS_PER_BIT-1; then sample rx_s into byte bit [index], clear counter; index<7 -> increment and stay; index==7 -> index=0, go STOP.
REQ-014 STOP: count until counter==CLKS_PER_BIT-1; then sample rx_s, go CLEANUP, o_Rx_Active=0.
REQ-015 STOP sample==1: next cycle o_Rx_DV=1 for exactly one cycle and o_Rx_Byte updated simultaneously.
REQ-016 STOP sample==0: no o_Rx_DV, o_Rx_Byte unchanged; frame-error handling per REQ-022/023.
REQ-017 CLEANUP: one cycle, clear pulses, go IDLE; a line low during CLEANUP SHALL be detected in IDLE next cycle.
REQ-018 Any undefined state encoding SHALL return to IDLE on the next clock.
REQ-019 o_Rx_DV and o_Rx_Frame_Err SHALL never be high in the same cycle nor for more than one cycle.

Reset
REQ-020 While i_Reset==1 at a clock edge: state=IDLE, counter=0, index=0, o_Rx_DV=0, o_Rx_Byte=8'h00, o_Rx_Active=0, o_Rx_Frame_Err=0, both synchronizer flops=1.
REQ-021 Reset mid-frame SHALL abandon the frame with no pulse; reception resumes on the first falling edge after reset release.

Configuration
REQ-022 With macro CAN_RX_FRAME_ERR_EN defined: stop sample==0 SHALL pulse o_Rx_Frame_Err for one cycle (same cycle DV would have been) and discard the byte.
REQ-023 Without CAN_RX_FRAME_ERR_EN: o_Rx_Frame_Err SHALL be tied 0; stop sample==0 discards the byte silently; port list is identical in both builds.

Verification (CLKS_PER_BIT=87, macro defined unless noted)
REQ-024 Frame 0x37 with stop=1 -> single o_Rx_DV pulse, o_Rx_Byte==8'h37, o_Rx_Frame_Err stays 0.
REQ-025 Line low for 20 cycles then high -> o_Rx_Active pulses high then low, no o_Rx_DV, no o_Rx_Frame_Err.
REQ-026 Frame 0xA5 with stop=0 -> one o_Rx_Frame_Err pulse, no o_Rx_DV, o_Rx_Byte keeps previous value; macro undefined -> no pulse on either output.
REQ-027 Back-to-back 0x00 then 0xFF with no idle gap -> two o_Rx_DV pulses, bytes 8'h00 then 8'hFF.
REQ-028 i_Reset asserted during data bit 4 of 0x5A, released, then frame 0xC3 -> no pulse for 0x5A, all outputs 0 during reset, then o_Rx_Byte==8'hC3 with one o_Rx_DV.
